// File: rtl/mips_cpu_pc_sequencer.sv
// PC sequencer for the multicycle MIPS core: fetches over a waitrequest bus, holds the
// instruction for execute, and steps the PC with a single branch delay slot and halt detect.
module mips_cpu_pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
    parameter logic [31:0] HALT_ADDR    = 32'h00000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_enable,
    output logic [31:0] pc_out,
    output logic        fetch_read,
    output logic [31:0] fetch_address,
    input  logic        fetch_waitrequest,
    input  logic [31:0] fetch_readdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        exec_done,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        delay_slot,
    output logic        active
);

    typedef enum logic [1:0] {
        S_FETCH,
        S_EXEC,
        S_HALTED
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic        delay_slot_q;
    logic        pending_q;
    logic [31:0] pending_target_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= S_FETCH;
            pc_q             <= RESET_VECTOR;
            instr_q          <= '0;
            delay_slot_q     <= 1'b0;
            pending_q        <= 1'b0;
            pending_target_q <= '0;
        end else if (clk_enable) begin
            case (state_q)
                S_FETCH: begin
                    if (!fetch_waitrequest) begin
                        instr_q <= fetch_readdata;
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (exec_done) begin
                        // A pending redirect retires the delay slot; any branch in the slot is dropped.
                        if (pending_q) begin
                            pc_q         <= pending_target_q;
                            pending_q    <= 1'b0;
                            delay_slot_q <= 1'b0;
                            state_q      <= (pending_target_q == HALT_ADDR) ? S_HALTED : S_FETCH;
                        end else begin
                            pc_q <= pc_q + 32'd4;
                            if (branch_taken) begin
                                pending_q        <= 1'b1;
                                pending_target_q <= branch_target & ~32'd3;
                                delay_slot_q     <= 1'b1;
                            end
                            state_q <= S_FETCH;
                        end
                    end
                end
                S_HALTED: ;
                default: state_q <= S_FETCH;
            endcase
        end
    end

    assign pc_out        = (state_q == S_HALTED) ? HALT_ADDR : pc_q;
    assign fetch_read    = (state_q == S_FETCH) && !reset;
    assign fetch_address = {pc_q[31:2], 2'b00};
    assign instr         = instr_q;
    assign instr_valid   = (state_q == S_EXEC);
    assign delay_slot    = delay_slot_q;
    assign active        = (state_q != S_HALTED);

endmodule
